// File: rtl/ddr2_pkg.sv
// rtl/ddr2_pkg.sv - shared DDR2 test-pattern constants, pattern function and checker state type
package ddr2_pkg;

    localparam int DDR2_DATA_W = 128;
    localparam int DDR2_LANES  = 4;
    localparam int DDR2_LANE_W = DDR2_DATA_W / DDR2_LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // Beat k carries k replicated into every 32-bit lane; the write-side
    // generator calls this same function so both ends agree by construction.
    function automatic logic [DDR2_DATA_W-1:0] exp_pattern(input logic [DDR2_LANE_W-1:0] k);
        return {DDR2_LANES{k}};
    endfunction

endpackage

// File: rtl/ddr2_beat_compare.sv
// rtl/ddr2_beat_compare.sv - two-stage beat compare pipeline producing a per-lane mismatch mask
//   clk_in    : clock
//   flush     : synchronous, drops every in-flight beat
//   in_valid  : beat accepted this cycle
//   in_data   : read data beat
//   in_index  : pattern index of the beat
//   out_valid : mask/index below are meaningful
//   out_mask  : bit i set if lane i differs from the expected pattern
//   out_index : pattern index belonging to out_mask
module ddr2_beat_compare
    import ddr2_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [DDR2_DATA_W-1:0] in_data,
    input  logic [31:0]            in_index,
    output logic                   out_valid,
    output logic [DDR2_LANES-1:0]  out_mask,
    output logic [31:0]            out_index
);

    logic                   s1_valid;
    logic [DDR2_DATA_W-1:0] s1_data;
    logic [DDR2_DATA_W-1:0] s1_exp;
    logic [31:0]            s1_index;
    logic [DDR2_LANES-1:0]  lane_mask;

    // Only the valid bits need flushing; payload registers are don't-care
    // whenever their valid is low.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk_in) begin
        s1_data   <= in_data;
        s1_exp    <= exp_pattern(in_index);
        s1_index  <= in_index;
        out_mask  <= lane_mask;
        out_index <= s1_index;
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < DDR2_LANES; i++) begin
            lane_mask[i] = (s1_data[i*DDR2_LANE_W +: DDR2_LANE_W] !=
                            s1_exp[i*DDR2_LANE_W +: DDR2_LANE_W]);
        end
    end

endmodule

// File: rtl/ddr2_read_data_checker.sv
// rtl/ddr2_read_data_checker.sv - checks DDR2 read beats against the stored pattern and reports pass/fail
//   clk_in            : UI clock
//   rst_n             : synchronous reset, active HIGH
//   enable            : beats accepted only while high
//   clear             : synchronous restart to IDLE with all results zeroed
//   app_rd_data       : read data beat
//   app_rd_data_valid : beat qualifier
//   app_rd_data_end   : end-of-burst, expected with every valid beat
//   busy, done, pass  : run status and verdict
//   beat_cnt          : accepted beats
//   err_cnt           : mismatching beats, saturating
//   lane_err          : sticky per-lane mismatch flags
//   first_err_beat    : index of the first mismatching beat
//   frame_err         : sticky framing violation
module ddr2_read_data_checker
    import ddr2_pkg::*;
#(
    parameter int unsigned NUM_BEATS = 1024,
    parameter int          ERR_W     = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [DDR2_DATA_W-1:0] app_rd_data,
    input  logic                   app_rd_data_valid,
    input  logic                   app_rd_data_end,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [31:0]            beat_cnt,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [DDR2_LANES-1:0]  lane_err,
    output logic [31:0]            first_err_beat,
    output logic                   frame_err
);

    localparam logic [31:0] LAST_IDX = 32'(NUM_BEATS - 1);

    chk_state_t            state;
    chk_state_t            state_nxt;
    logic [1:0]            drain_cnt;
    logic                  flush;
    logic                  accept;
    logic                  last_beat;
    logic                  cmp_valid;
    logic [DDR2_LANES-1:0] cmp_mask;
    logic [31:0]           cmp_index;

    assign flush     = rst_n | clear;
    assign accept    = app_rd_data_valid & enable &
                       ((state == ST_IDLE) | (state == ST_RUN));
    assign last_beat = (beat_cnt == LAST_IDX);

    ddr2_beat_compare u_cmp (
        .clk_in    (clk_in),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   (app_rd_data),
        .in_index  (beat_cnt),
        .out_valid (cmp_valid),
        .out_mask  (cmp_mask),
        .out_index (cmp_index)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = last_beat ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (accept && last_beat) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 2'd0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (flush) begin
            state          <= ST_IDLE;
            drain_cnt      <= 2'd0;
            beat_cnt       <= '0;
            err_cnt        <= '0;
            lane_err       <= '0;
            first_err_beat <= '0;
            frame_err      <= 1'b0;
        end else begin
            state <= state_nxt;

            // Three DRAIN cycles: loaded with 2, DONE taken when it reads 0.
            if (state != ST_DRAIN && state_nxt == ST_DRAIN) begin
                drain_cnt <= 2'd2;
            end else if (state == ST_DRAIN && drain_cnt != 2'd0) begin
                drain_cnt <= drain_cnt - 2'd1;
            end

            // The FSM stops accepting after index NUM_BEATS-1, so this never wraps.
            if (accept) begin
                beat_cnt <= beat_cnt + 32'd1;
            end

            if ((accept && !app_rd_data_end) ||
                (state == ST_DONE && app_rd_data_valid)) begin
                frame_err <= 1'b1;
            end

            if (cmp_valid && (cmp_mask != '0)) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (err_cnt == '0) begin
                    first_err_beat <= cmp_index;
                end
                lane_err <= lane_err | cmp_mask;
            end
        end
    end

    assign busy = (state == ST_RUN) | (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done & (err_cnt == '0) & ~frame_err;

endmodule

// File: tb/tb_ddr2_read_data_checker.sv
// tb/tb_ddr2_read_data_checker.sv - randomized self-checking bench with a transaction-level model
module tb_ddr2_read_data_checker;

    localparam int NB = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic [127:0] rd_data = '0;
    logic         rd_valid = 1'b0;
    logic         rd_end = 1'b0;

    logic         busy, done, pass, frame_err;
    logic [31:0]  beat_cnt, first_err_beat;
    logic [15:0]  err_cnt;
    logic [3:0]   lane_err;

    logic         busy2, done2, pass2, frame_err2;
    logic [31:0]  beat_cnt2, first_err_beat2;
    logic [1:0]   err_cnt2;
    logic [3:0]   lane_err2;

    always #5 clk = ~clk;

    ddr2_read_data_checker #(.NUM_BEATS(NB), .ERR_W(16)) dut (
        .clk_in(clk), .rst_n(rst), .enable(enable), .clear(clear),
        .app_rd_data(rd_data), .app_rd_data_valid(rd_valid), .app_rd_data_end(rd_end),
        .busy(busy), .done(done), .pass(pass), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
        .lane_err(lane_err), .first_err_beat(first_err_beat), .frame_err(frame_err)
    );

    ddr2_read_data_checker #(.NUM_BEATS(NB), .ERR_W(2)) dut2 (
        .clk_in(clk), .rst_n(rst), .enable(enable), .clear(clear),
        .app_rd_data(rd_data), .app_rd_data_valid(rd_valid), .app_rd_data_end(rd_end),
        .busy(busy2), .done(done2), .pass(pass2), .beat_cnt(beat_cnt2), .err_cnt(err_cnt2),
        .lane_err(lane_err2), .first_err_beat(first_err_beat2), .frame_err(frame_err2)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: edge numbers of acceptance decide everything.
    typedef struct {
        int         at;
        int         idx;
        logic [3:0] mask;
    } upd_t;

    upd_t       pq[$];
    upd_t       u;
    int         edge_n = 0;
    int         m_cnt = 0;
    int         m_last = -1;
    int         m_err = 0;
    int         m_first = 0;
    logic [3:0] m_lane = '0;
    bit         m_frame = 0;
    logic [3:0] mk;

    always @(posedge clk) begin
        edge_n++;
        if (rst || clear) begin
            m_cnt = 0; m_last = -1; m_err = 0; m_first = 0; m_lane = '0; m_frame = 0;
            pq.delete();
        end else begin
            while (pq.size() > 0 && pq[0].at == edge_n) begin
                u = pq.pop_front();
                if (u.mask != 0) begin
                    if (m_err == 0) m_first = u.idx;
                    m_err++;
                    m_lane |= u.mask;
                end
            end
            if (rd_valid) begin
                if (m_last < 0 && enable) begin
                    for (int i = 0; i < 4; i++) mk[i] = (rd_data[32*i +: 32] != 32'(m_cnt));
                    pq.push_back('{edge_n + 2, m_cnt, mk});
                    if (!rd_end) m_frame = 1;
                    if (m_cnt == NB - 1) m_last = edge_n;
                    m_cnt++;
                end else if (m_last >= 0 && edge_n >= m_last + 4) begin
                    m_frame = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            bit m_done, m_busy, m_pass;
            m_done = (m_last >= 0) && (edge_n >= m_last + 3);
            m_busy = (m_cnt > 0) && !m_done;
            m_pass = m_done && (m_err == 0) && !m_frame;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("beat_cnt", beat_cnt, m_cnt);
            chk("err_cnt", err_cnt, (m_err > 65535) ? 65535 : m_err);
            chk("lane_err", lane_err, m_lane);
            chk("frame_err", frame_err, m_frame);
            if (m_err != 0) chk("first_err_beat", first_err_beat, m_first);
            chk("busy2", busy2, m_busy);
            chk("done2", done2, m_done);
            chk("pass2", pass2, m_pass);
            chk("beat_cnt2", beat_cnt2, m_cnt);
            chk("err_cnt2", err_cnt2, (m_err > 3) ? 3 : m_err);
            chk("lane_err2", lane_err2, m_lane);
            chk("frame_err2", frame_err2, m_frame);
            if (m_err != 0) chk("first_err_beat2", first_err_beat2, m_first);
        end
    end

    task automatic step(input bit v, input bit en, input bit e, input logic [127:0] d, input bit c);
        @(negedge clk);
        rd_valid = v; enable = en; rd_end = e; rd_data = d; clear = c;
    endtask

    task automatic idle();
        step(0, 0, 1, '0, 0);
    endtask

    task automatic beat(input logic [31:0] k, input logic [3:0] m, input logic [31:0] x, input bit e);
        logic [127:0] d;
        d = {4{k}};
        for (int i = 0; i < 4; i++) if (m[i]) d[32*i +: 32] = d[32*i +: 32] ^ x;
        step(1, 1, e, d, 0);
    endtask

    task automatic do_clear();
        step(0, 0, 1, '0, 1);
        idle();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            idle();
            n++;
        end while (!done && n < 30);
        if (!done) chk("done_timeout", done, 1);
    endtask

    int n;
    logic [3:0]  rm;
    logic [31:0] rx;

    initial begin
        repeat (3) idle();
        rst = 1'b0;
        idle();
        chk("reset_beat_cnt", beat_cnt, 0);
        chk("reset_done", done, 0);
        chk("reset_err_cnt", err_cnt, 0);

        // Clean back-to-back run
        for (int k = 0; k < NB; k++) beat(k, 4'b0, 32'h0, 1);
        wait_done(n);
        chk("done_latency", n, 4);
        chk("good_beat_cnt", beat_cnt, 8);
        chk("good_err_cnt", err_cnt, 0);
        chk("good_pass", pass, 1);

        // Lane 2 of beat 5 inverted
        do_clear();
        for (int k = 0; k < NB; k++) beat(k, (k == 5) ? 4'b0100 : 4'b0, 32'hFFFFFFFF, 1);
        wait_done(n);
        chk("l2_err_cnt", err_cnt, 1);
        chk("l2_first", first_err_beat, 5);
        chk("l2_lane_err", lane_err, 4'b0100);
        chk("l2_pass", pass, 0);

        // Beats 3 and 6
        do_clear();
        for (int k = 0; k < NB; k++)
            beat(k, (k == 3) ? 4'b0001 : (k == 6) ? 4'b1000 : 4'b0, 32'h1, 1);
        wait_done(n);
        chk("two_err_cnt", err_cnt, 2);
        chk("two_first", first_err_beat, 3);

        // Every beat wrong: 2-bit counter saturates
        do_clear();
        for (int k = 0; k < NB; k++) beat(k, 4'($urandom_range(1, 15)), $urandom | 1, 1);
        wait_done(n);
        chk("sat_err_cnt2", err_cnt2, 3);
        chk("sat_first2", first_err_beat2, 0);
        chk("sat_err_cnt", err_cnt, 8);

        // Missing end on beat 2, then a beat after done
        do_clear();
        for (int k = 0; k < NB; k++) beat(k, 4'b0, 32'h0, k != 2);
        wait_done(n);
        beat(8, 4'b0, 32'h0, 1);
        idle();
        chk("frm_frame_err", frame_err, 1);
        chk("frm_beat_cnt", beat_cnt, 8);
        chk("frm_pass", pass, 0);

        // Clear with a corrupted beat 5 still in the pipeline
        do_clear();
        for (int k = 0; k < 6; k++) beat(k, (k == 5) ? 4'b1111 : 4'b0, 32'h55, 1);
        step(0, 0, 1, '0, 1);
        idle();
        chk("clr_beat_cnt", beat_cnt, 0);
        chk("clr_busy", busy, 0);
        repeat (3) idle();
        chk("clr_err_cnt", err_cnt, 0);
        for (int k = 0; k < NB; k++) beat(k, 4'b0, 32'h0, 1);
        wait_done(n);
        chk("clr_rerun_pass", pass, 1);

        // Valid beats while disabled
        do_clear();
        for (int k = 0; k < 5; k++) step(1, 0, 1, {4{32'(k)}}, 0);
        idle();
        chk("dis_beat_cnt", beat_cnt, 0);
        chk("dis_busy", busy, 0);

        // Randomized runs with gaps, disabled beats, corruption and framing errors
        for (int r = 0; r < 8; r++) begin
            do_clear();
            for (int k = 0; k < NB; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 1) == 1)
                        step(1, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
                    else
                        idle();
                end
                rm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
                rx = $urandom | 1;
                beat(k, rm, rx, $urandom_range(0, 15) != 0);
            end
            wait_done(n);
            chk("rand_done_latency", n, 4);
            if ($urandom_range(0, 1) == 1) beat(8, 4'b0, 32'h0, 1);
            idle();
            idle();
        end

        // Reset mid-run
        do_clear();
        for (int k = 0; k < 4; k++) beat(k, 4'b0010, 32'h3, 1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        repeat (4) idle();
        chk("rst_mid_err_cnt", err_cnt, 0);
        chk("rst_mid_beat_cnt", beat_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
